// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: responder for the MEM-stage enableMem/readWriteMem interface.
// Each LW/SW takes a fixed number of cycles. The pipeline is stalled while the
// access is in flight, and a one-cycle done pulse marks completion.
// The word storage array lives here and is never cleared by reset.

module data_mem_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              stall,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter starts at LATENCY-1, so BUSY lasts exactly LATENCY cycles.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    wr_q;
    logic [DEPTH_LOG2:0]     addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       mem [0:(2**DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]   word;
    logic                    finishing;
    logic                    unused_addr_hi;

    // Address bits above the word index are dropped, so accesses alias.
    assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2+1];
    assign word           = addr_q[DEPTH_LOG2:1];
    assign finishing      = (state == BUSY) && (cnt == 4'd0);

    // Stall the requester immediately in IDLE, and hold the stall through BUSY.
    // Stall is forced low while reset is asserted.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            stall = ((state == IDLE) && enable) || (state == BUSY);
        end
    end

    // Request sequencing: latch the request, count down the latency, then complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        wr_q    <= wr;
                        addr_q  <= addr[DEPTH_LOG2:0];
                        wdata_q <= wdata;
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!wr_q) begin
                            rdata <= mem[word];
                        end
                        misaligned <= addr_q[0];
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage write on the completing edge of a store. There is no reset,
    // so the contents survive rst_n.
    always_ff @(posedge clk) begin
        if (finishing && wr_q) begin
            mem[word] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: drives two controller instances, one with LATENCY=4 and one
// with LATENCY=1. A transaction-timeline model predicts stall, done, misaligned
// and rdata on every cycle.

module tb_data_mem_ctrl;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    [2];
    logic        wr    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic [15:0] rdataV[2];
    logic        doneV [2];
    logic        stallV[2];
    logic        misV  [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: at most one transaction per instance.
    bit          active [2];
    int          reqC   [2];
    bit          qWr    [2];
    logic [15:0] qAddr  [2];
    logic [15:0] qData  [2];
    logic [15:0] mMem   [2][1024];
    bit          mKn    [2][1024];
    logic [15:0] expRd  [2];
    bit          rdKn   [2];

    data_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .wr(wr[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdataV[0]), .done(doneV[0]), .stall(stallV[0]),
        .misaligned(misV[0])
    );

    data_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .wr(wr[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdataV[1]), .done(doneV[1]), .stall(stallV[1]),
        .misaligned(misV[1])
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index; each posedge starts a new cycle
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model plus compare, evaluated mid-cycle on every cycle.
    // A request accepted in cycle c stalls cycles c..c+L and completes in cycle c+L+1.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit doneNow;
            bit busyNow;
            int w;
            doneNow = active[i] && (cyc == reqC[i] + latOf(i) + 1);
            busyNow = active[i] && (cyc <= reqC[i] + latOf(i));
            w = int'(qAddr[i][10:1]);
            if (doneNow && qWr[i]) begin
                mMem[i][w] = qData[i];
                mKn[i][w]  = 1'b1;
            end
            if (!rst_n) begin
                active[i] = 1'b0;
                expRd[i]  = 16'h0000;
                rdKn[i]   = 1'b1;
                checkOutput($sformatf("rst_stall%0d", i), 32'(stallV[i]), 32'd0);
                checkOutput($sformatf("rst_done%0d", i), 32'(doneV[i]), 32'd0);
                checkOutput($sformatf("rst_mis%0d", i), 32'(misV[i]), 32'd0);
                checkOutput($sformatf("rst_rdata%0d", i), 32'(rdataV[i]), 32'd0);
            end else if (doneNow) begin
                if (!qWr[i]) begin
                    expRd[i] = mMem[i][w];
                    rdKn[i]  = mKn[i][w];
                end
                checkOutput($sformatf("done_stall%0d", i), 32'(stallV[i]), 32'd0);
                checkOutput($sformatf("done%0d", i), 32'(doneV[i]), 32'd1);
                checkOutput($sformatf("mis%0d", i), 32'(misV[i]), 32'(qAddr[i][0]));
                active[i] = 1'b0;
            end else if (busyNow) begin
                checkOutput($sformatf("busy_stall%0d", i), 32'(stallV[i]), 32'd1);
                checkOutput($sformatf("busy_done%0d", i), 32'(doneV[i]), 32'd0);
            end else begin
                checkOutput($sformatf("idle_stall%0d", i), 32'(stallV[i]), 32'(en[i]));
                checkOutput($sformatf("idle_done%0d", i), 32'(doneV[i]), 32'd0);
                if (en[i]) begin
                    active[i] = 1'b1;
                    reqC[i]   = cyc;
                    qWr[i]    = wr[i];
                    qAddr[i]  = addr[i];
                    qData[i]  = wdata[i];
                end
            end
            if (rst_n && rdKn[i]) begin
                checkOutput($sformatf("rdata%0d", i), 32'(rdataV[i]), 32'(expRd[i]));
            end
        end
    end

    // Issue one access and wait, bounded, for its done pulse.
    // mode 0: hold inputs; mode 1: scramble inputs while busy; mode 2: drop enable, addr=0x0020.
    task automatic applyStimulus(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                                 input int mode, output int stallCnt, output int latency,
                                 output logic [15:0] rd, output logic mis, output int doneAt);
        int startC;
        @(posedge clk); #1;
        en[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
        startC   = cyc;
        stallCnt = 0;
        latency  = -1;
        rd       = 16'h0000;
        mis      = 1'b0;
        doneAt   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stallV[i]) stallCnt++;
            if (doneV[i]) begin
                latency = cyc - startC;
                rd      = rdataV[i];
                mis     = misV[i];
                doneAt  = cyc;
                break;
            end
            @(posedge clk); #1;
            if (mode == 1) begin
                en[i] = 1'($urandom); wr[i] = 1'($urandom);
                addr[i] = 16'($urandom); wdata[i] = 16'($urandom);
            end else if (mode == 2) begin
                en[i] = 1'b0; addr[i] = 16'h0020;
            end
        end
        if (latency < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout inst=%0d actual=no_done required=done_within_40", i);
        end
    endtask

    // Idle for n cycles with enable low, counting any done pulses seen
    task automatic idleCycles(input int i, input int n, output int dones);
        dones = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            en[i] = 1'b0;
            @(negedge clk);
            if (doneV[i]) dones++;
        end
    endtask

    initial begin
        int sc, lt, da, dn, prevDone;
        logic [15:0] rd;
        logic mis;
        logic [15:0] a;

        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b1; wr[i] = 1'b0; addr[i] = 16'h0000; wdata[i] = 16'h0000;
        end
        // Reset held with enable high: stall must stay low
        repeat (3) @(posedge clk);
        #1;
        en[0] = 1'b0; en[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idleCycles(0, 2, dn);

        // Store then load at 0x0010, LATENCY=4
        applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, 0, sc, lt, rd, mis, da);
        checkOutput("t1_stall_cycles", 32'(sc), 32'd5);
        checkOutput("t1_done_latency", 32'(lt), 32'd5);
        checkOutput("t1_mis", 32'(mis), 32'd0);
        checkOutput("t1_sw_rdata_kept", 32'(rd), 32'd0);
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 0, sc, lt, rd, mis, da);
        checkOutput("t1_lw_rdata", 32'(rd), 32'hBEEF);

        // Load whose inputs change mid-flight still uses the latched address
        applyStimulus(0, 1'b1, 16'h0020, 16'h0BAD, 0, sc, lt, rd, mis, da);
        applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 2, sc, lt, rd, mis, da);
        checkOutput("t2_rdata", 32'(rd), 32'hBEEF);
        idleCycles(0, 6, dn);
        checkOutput("t2_extra_done", 32'(dn), 32'd0);

        // Misaligned store is flagged and performed on the truncated word
        applyStimulus(0, 1'b1, 16'h0031, 16'h1234, 0, sc, lt, rd, mis, da);
        checkOutput("t3_sw_mis", 32'(mis), 32'd1);
        applyStimulus(0, 1'b0, 16'h0030, 16'h0000, 0, sc, lt, rd, mis, da);
        checkOutput("t3_lw_rdata", 32'(rd), 32'h1234);
        checkOutput("t3_lw_mis", 32'(mis), 32'd0);

        // Reset during BUSY aborts the store
        applyStimulus(0, 1'b1, 16'h0040, 16'h5555, 0, sc, lt, rd, mis, da);
        @(posedge clk); #1;
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0040; wdata[0] = 16'hAAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t4_stall", 32'(stallV[0]), 32'd0);
        checkOutput("t4_rdata", 32'(rdataV[0]), 32'd0);
        @(posedge clk); #1;
        en[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idleCycles(0, 2, dn);
        applyStimulus(0, 1'b0, 16'h0040, 16'h0000, 0, sc, lt, rd, mis, da);
        checkOutput("t4_lw_rdata", 32'(rd), 32'h5555);

        // Upper address bits alias to word 0
        applyStimulus(0, 1'b1, 16'h0000, 16'h7777, 0, sc, lt, rd, mis, da);
        applyStimulus(0, 1'b0, 16'h0800, 16'h0000, 0, sc, lt, rd, mis, da);
        checkOutput("t6_alias_rdata", 32'(rd), 32'h7777);

        // Randomised traffic on instance 0 with scrambled inputs while busy
        for (int w = 0; w < 16; w++) begin
            applyStimulus(0, 1'b1, 16'(w << 1), 16'($urandom), 0, sc, lt, rd, mis, da);
        end
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom);
            a[10:5] = 6'd0;
            applyStimulus(0, 1'($urandom), a, 16'($urandom), 1, sc, lt, rd, mis, da);
            if ($urandom_range(0, 2) != 0) idleCycles(0, $urandom_range(1, 3), dn);
        end
        idleCycles(0, 1, dn);

        // LATENCY=1: back-to-back stream, done every third cycle
        for (int w = 0; w < 8; w++) begin
            applyStimulus(1, 1'b1, 16'(w << 1), 16'($urandom), 0, sc, lt, rd, mis, da);
        end
        prevDone = da;
        for (int k = 0; k < 12; k++) begin
            a = 16'($urandom);
            a[10:4] = 7'd0;
            applyStimulus(1, 1'($urandom), a, 16'($urandom), 0, sc, lt, rd, mis, da);
            checkOutput("t5_stall_cycles", 32'(sc), 32'd2);
            checkOutput("t5_done_spacing", 32'(da - prevDone), 32'd3);
            prevDone = da;
        end
        idleCycles(1, 4, dn);
        checkOutput("t5_extra_done", 32'(dn), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
